ks_program_memory: RTL and testbench



---
 rtl/k_and_s_pkg.sv | 13 +
 rtl/ks_sync_ram.sv | 44 ++++
 rtl/ks_program_memory.sv | 130 +++++++++++++
 tb/tb_ks_program_memory.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and sizing constants for the K&S processor and its memory-side blocks.
package k_and_s_pkg;

  localparam int KS_ADDR_W = 5;
  localparam int KS_DATA_W = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    RUN  = 2'd2
  } loader_state_type;

endpackage

// File: rtl/ks_sync_ram.sv
// Single-port-style synchronous RAM: one write port, one registered read port,
// read-first on address collision, 1-cycle read latency.
module ks_sync_ram
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W = KS_ADDR_W,
  parameter int DATA_W = KS_DATA_W,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = mem_q[raddr];
  end

  // Array contents deliberately survive reset so a reset mid-load keeps earlier words.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ks_program_memory.sv
// Program memory for the K&S core: boot loader FSM filling RAM from address 0,
// core reset hold until loading completes, and the core's read/write port.
module ks_program_memory
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W = KS_ADDR_W,
  parameter int DATA_W = KS_DATA_W,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_write_enable,
  output logic [DATA_W-1:0] ram_rdata,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic [ADDR_W:0]   load_count,
  output logic              load_overflow,
  output logic              core_hold
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  loader_state_type state_q, state_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             core_hold_q, core_hold_d;

  logic              transfer_s;
  logic              core_we_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;

  assign load_ready = (state_q == LOAD) && !rst;
  assign transfer_s = load_valid && load_ready;
  assign core_we_s  = ram_write_enable && (state_q == RUN) && !rst;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      LOAD: begin
        if (transfer_s) begin
          count_d = count_q + ONE;
          // The 32nd word always ends the load so the write pointer never wraps.
          if (load_last || (count_q == LAST_IDX)) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
          if (!load_last && (count_q == LAST_IDX)) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = RUN;
      end
      RUN: begin
        if (load_start) begin
          state_d    = LOAD;
          count_d    = {(ADDR_W+1){1'b0}};
          overflow_d = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    core_hold_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      count_q     <= {(ADDR_W+1){1'b0}};
      overflow_q  <= 1'b0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      core_hold_q <= core_hold_d;
    end
  end

  // Loader and core writes are mutually exclusive by state, so a simple mux suffices.
  always_comb begin
    if (transfer_s) begin
      ram_waddr_s = count_q[ADDR_W-1:0];
      ram_wdata_s = load_data;
    end else begin
      ram_waddr_s = ram_addr;
      ram_wdata_s = ram_wdata;
    end
    ram_we_s = transfer_s || core_we_s;
  end

  ks_sync_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we_s),
    .waddr(ram_waddr_s),
    .wdata(ram_wdata_s),
    .raddr(ram_addr),
    .rdata(ram_rdata)
  );

  assign load_count    = count_q;
  assign load_overflow = overflow_q;
  assign core_hold     = core_hold_q;

endmodule

// File: tb/tb_ks_program_memory.sv
// Directed self-checking bench for ks_program_memory.
module tb_ks_program_memory;

  logic        clk;
  logic        rst;
  logic [4:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_write_enable;
  logic [15:0] ram_rdata;
  logic        load_start;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;
  logic [5:0]  load_count;
  logic        load_overflow;
  logic        core_hold;

  int n_cmp = 0;
  int n_err = 0;

  ks_program_memory dut (
    .clk             (clk),
    .rst             (rst),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_write_enable(ram_write_enable),
    .ram_rdata       (ram_rdata),
    .load_start      (load_start),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .load_last       (load_last),
    .load_count      (load_count),
    .load_overflow   (load_overflow),
    .core_hold       (core_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (load_count !== 6'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", load_count); end
    n_cmp++; if (core_hold !== 1'b1) begin n_err++; $display("FAIL reset_hold got=%b exp=1", core_hold); end
    n_cmp++; if (ram_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata got=%h exp=0000", ram_rdata); end
    n_cmp++; if (load_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", load_overflow); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst got=%b exp=0", load_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got=%b exp=1", load_ready); end
  endtask

  task automatic test_load3();
    logic [15:0] words [3];
    words[0] = 16'h8101; words[1] = 16'h8202; words[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == 2);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_cmp++; if (load_count !== 6'd3) begin n_err++; $display("FAIL load3_count got=%0d exp=3", load_count); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL load3_done_ready got=%b exp=0", load_ready); end
    n_cmp++; if (core_hold !== 1'b1) begin n_err++; $display("FAIL load3_done_hold got=%b exp=1", core_hold); end
    tick();
    n_cmp++; if (core_hold !== 1'b0) begin n_err++; $display("FAIL load3_run_hold got=%b exp=0", core_hold); end
    for (int i = 0; i < 3; i++) begin
      ram_addr = 5'(i);
      tick();
      n_cmp++; if (ram_rdata !== words[i]) begin n_err++; $display("FAIL load3_read%0d got=%h exp=%h", i, ram_rdata, words[i]); end
    end
  endtask

  task automatic test_overflow();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_data  = 16'hA000 + 16'(i);
      load_last  = 1'b0;
      tick();
    end
    n_cmp++; if (load_count !== 6'd32) begin n_err++; $display("FAIL ovf_count got=%0d exp=32", load_count); end
    n_cmp++; if (load_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", load_overflow); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready got=%b exp=0", load_ready); end
    load_data = 16'hBEEF;
    tick();
    load_valid = 1'b0;
    n_cmp++; if (core_hold !== 1'b0) begin n_err++; $display("FAIL ovf_run_hold got=%b exp=0", core_hold); end
    ram_addr = 5'd0;
    tick();
    n_cmp++; if (ram_rdata !== 16'hA000) begin n_err++; $display("FAIL ovf_mem0 got=%h exp=a000", ram_rdata); end
    ram_addr = 5'd31;
    tick();
    n_cmp++; if (ram_rdata !== 16'hA01F) begin n_err++; $display("FAIL ovf_mem31 got=%h exp=a01f", ram_rdata); end
  endtask

  task automatic test_core_write();
    ram_addr         = 5'd5;
    ram_wdata        = 16'h1234;
    ram_write_enable = 1'b1;
    tick();
    ram_write_enable = 1'b0;
    n_cmp++; if (ram_rdata !== 16'hA005) begin n_err++; $display("FAIL wr_read_first got=%h exp=a005", ram_rdata); end
    tick();
    n_cmp++; if (ram_rdata !== 16'h1234) begin n_err++; $display("FAIL wr_new got=%h exp=1234", ram_rdata); end
  endtask

  task automatic test_reload();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_cmp++; if (core_hold !== 1'b1) begin n_err++; $display("FAIL reload_hold got=%b exp=1", core_hold); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reload_ready got=%b exp=1", load_ready); end
    n_cmp++; if (load_count !== 6'd0) begin n_err++; $display("FAIL reload_count got=%0d exp=0", load_count); end
    n_cmp++; if (load_overflow !== 1'b0) begin n_err++; $display("FAIL reload_ovf got=%b exp=0", load_overflow); end
    load_valid = 1'b1;
    load_data  = 16'h5555;
    load_last  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_cmp++; if (load_count !== 6'd1) begin n_err++; $display("FAIL reload_count1 got=%0d exp=1", load_count); end
    tick();
    n_cmp++; if (core_hold !== 1'b0) begin n_err++; $display("FAIL reload_run got=%b exp=0", core_hold); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reload_run_ready got=%b exp=0", load_ready); end
  endtask

  task automatic test_load_gating();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ram_addr         = 5'd7;
    ram_wdata        = 16'hDEAD;
    ram_write_enable = 1'b1;
    tick();
    ram_write_enable = 1'b0;
    tick();
    n_cmp++; if (ram_rdata !== 16'hA007) begin n_err++; $display("FAIL gate_mem7 got=%h exp=a007", ram_rdata); end
    load_valid = 1'b1; load_data = 16'h1111;
    tick();
    n_cmp++; if (load_count !== 6'd1) begin n_err++; $display("FAIL bp_count_a got=%0d exp=1", load_count); end
    load_valid = 1'b0; load_data = 16'h9999;
    tick();
    n_cmp++; if (load_count !== 6'd1) begin n_err++; $display("FAIL bp_count_b got=%0d exp=1", load_count); end
    load_valid = 1'b1; load_data = 16'h2222;
    tick();
    n_cmp++; if (load_count !== 6'd2) begin n_err++; $display("FAIL bp_count_c got=%0d exp=2", load_count); end
    load_data = 16'h3333; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    n_cmp++; if (core_hold !== 1'b0) begin n_err++; $display("FAIL bp_run got=%b exp=0", core_hold); end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp_w;
      exp_w = (i == 0) ? 16'h1111 : (i == 1) ? 16'h2222 : 16'h3333;
      ram_addr = 5'(i);
      tick();
      n_cmp++; if (ram_rdata !== exp_w) begin n_err++; $display("FAIL bp_read%0d got=%h exp=%h", i, ram_rdata, exp_w); end
    end
    ram_addr = 5'd7;
    tick();
    n_cmp++; if (ram_rdata !== 16'hA007) begin n_err++; $display("FAIL gate_mem7_run got=%h exp=a007", ram_rdata); end
  endtask

  task automatic test_reset_midload();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ram_addr = 5'd1;
    load_valid = 1'b1; load_data = 16'hC0C0;
    tick();
    load_data = 16'hC1C1;
    tick();
    load_valid = 1'b0;
    n_cmp++; if (load_count !== 6'd2) begin n_err++; $display("FAIL mid_count2 got=%0d exp=2", load_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (load_count !== 6'd0) begin n_err++; $display("FAIL mid_count0 got=%0d exp=0", load_count); end
    n_cmp++; if (ram_rdata !== 16'h0000) begin n_err++; $display("FAIL mid_rdata got=%h exp=0000", ram_rdata); end
    n_cmp++; if (core_hold !== 1'b1) begin n_err++; $display("FAIL mid_hold got=%b exp=1", core_hold); end
    load_valid = 1'b1; load_data = 16'h7777; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    n_cmp++; if (core_hold !== 1'b0) begin n_err++; $display("FAIL mid_run got=%b exp=0", core_hold); end
    ram_addr = 5'd0;
    tick();
    n_cmp++; if (ram_rdata !== 16'h7777) begin n_err++; $display("FAIL mid_mem0 got=%h exp=7777", ram_rdata); end
    ram_addr = 5'd1;
    tick();
    n_cmp++; if (ram_rdata !== 16'hC1C1) begin n_err++; $display("FAIL mid_mem1 got=%h exp=c1c1", ram_rdata); end
    ram_addr = 5'd2;
    tick();
    n_cmp++; if (ram_rdata !== 16'h3333) begin n_err++; $display("FAIL mid_mem2 got=%h exp=3333", ram_rdata); end
  endtask

  initial begin
    rst = 1'b1;
    ram_addr = 5'd0;
    ram_wdata = 16'h0000;
    ram_write_enable = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data = 16'h0000;
    load_last = 1'b0;
    test_reset();
    test_load3();
    test_overflow();
    test_core_write();
    test_reload();
    test_load_gating();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
